// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample
//   Oversampling serial receiver. The line is synchronised, the start bit is
//   qualified at mid-bit, and each data bit (LSB first) is sampled at its centre.
//   A good stop bit delivers the byte with a one-cycle rx_done strobe.
//   A low stop bit gives a one-cycle frame_err strobe instead.
//
//   Optional feature macro: UART_RX_PARITY_EN
//     Adds an even-parity bit after the data bits and a parity_err output.
//
//   Ports
//     rx_clk            system clock, rising edge
//     rst_n             asynchronous active-low reset
//     rx_serial_data    asynchronous serial line, idle high
//     rx_parallel_data  last correctly framed byte
//     rx_done           1-cycle strobe when rx_parallel_data updates
//     rx_busy           high from start-edge detect until return to IDLE
//     frame_err         1-cycle strobe when the stop bit is sampled low
//     parity_err        (UART_RX_PARITY_EN only) strobes with rx_done on bad parity
//
//   state  | meaning
//   IDLE   | waiting for a falling edge on an armed (previously high) line
//   START  | counting to mid start bit, then confirming it is still low
//   DATA   | sampling DATA_BITS data bits, one per CLK_DIV cycles
//   PARITY | sampling the parity bit (UART_RX_PARITY_EN only)
//   STOP   | sampling the stop bit and delivering the byte or a frame error
module uart_rx_oversample #(
  parameter int CLK_DIV   = 16,
  parameter int DATA_BITS = 8
) (
  input  logic                 rx_clk,
  input  logic                 rst_n,
  input  logic                 rx_serial_data,
  output logic [DATA_BITS-1:0] rx_parallel_data,
  output logic                 rx_done,
  output logic                 rx_busy,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 frame_err
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state;
  logic                 sync1, sync2;
  logic                 armed;
  logic [CW-1:0]        bit_cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shift_reg;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit;
`endif

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rx_serial_data;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      armed            <= 1'b0;
      bit_cnt          <= '0;
      idx              <= '0;
      shift_reg        <= '0;
      rx_parallel_data <= '0;
      rx_done          <= 1'b0;
      rx_busy          <= 1'b0;
      frame_err        <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit          <= 1'b0;
      parity_err       <= 1'b0;
`endif
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // armed only after the line has been seen high, so a stuck-low
          // line following a frame error cannot start a new frame
          if (sync2) begin
            armed <= 1'b1;
          end else if (armed) begin
            state   <= START;
            bit_cnt <= '0;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (bit_cnt == CNT_HALF) begin
            bit_cnt <= '0;
            idx     <= '0;
            if (!sync2) begin
              state <= DATA;
            end else begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_cnt == CNT_FULL) begin
            bit_cnt   <= '0;
            shift_reg <= {sync2, shift_reg[DATA_BITS-1:1]};
            idx       <= idx + IW'(1);
            if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (bit_cnt == CNT_FULL) begin
            bit_cnt <= '0;
            par_bit <= sync2;
            state   <= STOP;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          // leaving at mid-stop-bit leaves half a bit to catch an
          // immediately following start edge
          if (bit_cnt == CNT_FULL) begin
            bit_cnt <= '0;
            state   <= IDLE;
            rx_busy <= 1'b0;
            if (sync2) begin
              rx_parallel_data <= shift_reg;
              rx_done          <= 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_err       <= (^shift_reg) ^ par_bit;
`endif
            end else begin
              frame_err <= 1'b1;
              armed     <= 1'b0;
            end
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
